sra_pipe: RTL and testbench

- Pipelined 32-bit right shifter, arithmetic or logical; the companion to the ALU's combinational left barrel shifter.
- Structure: one pipeline stage per barrel level, ordered 16, 8, 4, 2, 1.
- Valid/ready handshake on both sides with full backpressure; sustains one result per cycle when unstalled.
- Sits between operand issue and the ALU result/writeback mux on the sra/srl path.

---
 rtl/sra_pipe.sv | 78 +++++++
 tb/tb_sra_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sra_pipe.sv
// sra_pipe: pipelined right shifter, one barrel level per stage (16, 8, 4, 2, 1),
// arithmetic or logical fill, valid/ready on both sides with bubble-collapsing backpressure.
module sra_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    logic [SHW-1:0][WIDTH-1:0] data_q, data_d, src_data;
    logic [SHW-2:0][SHW-1:0]   shamt_q, shamt_d;
    logic [SHW-1:0][SHW-1:0]   src_shamt;
    logic [SHW-2:0]            arith_q, arith_d;
    logic [SHW-1:0]            src_arith, src_valid, valid_q, valid_d;
    logic [SHW:0]              adv;
    logic [2*WIDTH-1:0]        wide;
    // The last stage needs no shamt/arith: its shift is applied on the way in.
    always_comb begin
        adv = '0;
        adv[SHW] = out_ready;
        for (int k = SHW-1; k >= 0; k--) adv[k] = !valid_q[k] | adv[k+1];
        src_data = '0;
        src_shamt = '0;
        src_arith = '0;
        src_valid = '0;
        src_data[0] = in_data;
        src_shamt[0] = in_shamt;
        src_arith[0] = in_arith;
        src_valid[0] = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_data[k] = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_arith[k] = arith_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
        wide = '0;
        data_d = '0;
        valid_d = '0;
        for (int k = 0; k < SHW; k++) begin
            wide = {{WIDTH{src_arith[k] & src_data[k][WIDTH-1]}}, src_data[k]}
                   >> (src_shamt[k] & SHW'(1 << (SHW-1-k)));
            data_d[k] = adv[k] ? wide[WIDTH-1:0] : data_q[k];
            valid_d[k] = adv[k] ? src_valid[k] : valid_q[k];
        end
        shamt_d = '0;
        arith_d = '0;
        for (int k = 0; k < SHW-1; k++) begin
            shamt_d[k] = adv[k] ? src_shamt[k] : shamt_q[k];
            arith_d[k] = adv[k] ? src_arith[k] : arith_q[k];
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            shamt_q <= '0;
            arith_q <= '0;
            valid_q <= '0;
        end else begin
            data_q <= data_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            valid_q <= valid_d;
        end
    end
    assign in_ready = adv[0];
    assign out_valid = valid_q[SHW-1];
    assign out_data = data_q[SHW-1];
    assign busy = |valid_q;
endmodule

// File: tb/tb_sra_pipe.sv
// tb_sra_pipe: scoreboard bench for sra_pipe; expected results come from a plain
// arithmetic shift model and are compared whenever an output transfer occurs.
module tb_sra_pipe;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, in_arith, out_valid, out_ready, busy;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;

    typedef struct {logic [31:0] v; int t;} exp_t;
    exp_t        q[$];
    exp_t        e;
    int          out_times[$];
    logic [31:0] out_vals[$];
    int          checks = 0, failures = 0, cyc = 0, last_lat = 0;
    logic [31:0] last_out = '0;
    logic        rdone;

    sra_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_arith(in_arith),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_sh(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, a, x);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%h expected=none", out_data);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.v);
                last_lat = cyc - e.t;
                last_out = out_data;
                out_times.push_back(cyc);
                out_vals.push_back(out_data);
            end
        end
        if (reset && in_valid && in_ready) q.push_back('{ref_sh(in_data, in_shamt, in_arith), cyc});
    end

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a);
        int n = 0;
        logic acc;
        in_valid = 1'b1;
        in_data = d;
        in_shamt = s;
        in_arith = a;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) check("send_timeout", 32'(n), 32'(0));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 32'(q.size()), 32'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic [31:0] d, input logic [4:0] s, input logic a, input logic [31:0] x, input string n);
        send(d, s, a);
        drain();
        check(n, last_out, x);
    endtask

    initial begin
        logic [31:0] bp_d[8];
        logic [4:0]  bp_s[8];
        logic        bp_a[8];
        logic [31:0] held;
        logic        have, bad;
        int          acc, base;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_shamt = '0;
        in_arith = 1'b0;
        out_ready = 1'b1;
        rdone = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_data", out_data, 32'h0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clock);
        #1;

        // directed single ops and boundaries
        op(32'h80000000, 5'd4, 1'b1, 32'hF8000000, "sra4");
        check("latency", 32'(last_lat), 32'(5));
        op(32'h80000000, 5'd4, 1'b0, 32'h08000000, "srl4");
        op(32'hDEADBEEF, 5'd0, 1'b1, 32'hDEADBEEF, "sh0");
        op(32'hDEADBEEF, 5'd31, 1'b1, 32'hFFFFFFFF, "sra31");
        op(32'hDEADBEEF, 5'd31, 1'b0, 32'h00000001, "srl31");
        op(32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, "sra31_pos");

        // back-to-back
        base = out_times.size();
        for (int i = 0; i < 8; i++) send(32'h80000000, 5'(i), i % 2 == 0);
        drain();
        check("b2b_count", 32'(out_times.size() - base), 32'(8));
        check("b2b_consecutive", 32'(out_times[base+7] - out_times[base]), 32'(7));
        check("b2b_op1", out_vals[base+1], 32'h40000000);
        check("b2b_op2", out_vals[base+2], 32'hE0000000);

        // backpressure
        for (int i = 0; i < 8; i++) begin
            bp_d[i] = $urandom;
            bp_s[i] = 5'($urandom_range(0, 31));
            bp_a[i] = 1'($urandom_range(0, 1));
        end
        base = out_times.size();
        out_ready = 1'b0;
        acc = 0;
        have = 1'b0;
        bad = 1'b0;
        held = '0;
        repeat (10) begin
            in_valid = acc < 7;
            in_data = bp_d[acc];
            in_shamt = bp_s[acc];
            in_arith = bp_a[acc];
            @(negedge clock);
            if (in_ready && in_valid) acc++;
            if (out_valid) begin
                if (!have) held = out_data;
                else if (out_data !== held) bad = 1'b1;
                have = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("bp_accepted", 32'(acc), 32'(5));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_hold_data", out_data, ref_sh(bp_d[0], bp_s[0], bp_a[0]));
        check("bp_stable", 32'(bad), 32'(0));
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int i = acc; i < 7; i++) send(bp_d[i], bp_s[i], bp_a[i]);
        drain();
        check("bp_drained", 32'(out_times.size() - base), 32'(7));

        // bubble collapse
        send(32'h12345678, 5'd3, 1'b0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        send(32'h87654321, 5'd5, 1'b1);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (!in_ready || !out_valid) bad = 1'b1;
            @(posedge clock);
            #1;
        end
        check("bubble_in_ready", 32'(bad), 32'(0));
        @(negedge clock);
        check("bubble_out_data", out_data, 32'h12345678 >> 3);
        check("bubble_b_at_s3", 32'(dut.valid_q), 32'(5'b11000));
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain();
        check("bubble_b_result", last_out, 32'hFC3B2A19);

        // async reset mid-stream
        for (int i = 0; i < 3; i++) send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        #3;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        q.delete();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        @(negedge clock);
        check("arst_in_ready", 32'(in_ready), 32'(1));
        check("arst_out_data", out_data, 32'h0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (out_valid || busy) bad = 1'b1;
        end
        check("arst_no_stale", 32'(bad), 32'(0));
        @(posedge clock);
        #1;

        // randomized traffic with random backpressure
        base = out_times.size();
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clock);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rand_count", 32'(out_times.size() - base), 32'(300));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
